// File: rtl/pfpu_wbcollect.sv
// pfpu_wbcollect: write-back collector for the PFPU ALU units.
// A delay line of LAT_MAX slots tracks which destination register each
// issued instruction will retire into. When the head slot lines up with the
// ALU valid strobe, the result is written to the register file one cycle later.
// Optional error detection (slot collision, illegal latency, orphan result)
// is compiled in only when PFPU_WBCOLLECT_ERR_EN is defined; otherwise both
// error flags are tied low.
module pfpu_wbcollect #(
  parameter int LAT_MAX = 7,
  parameter int REG_AW  = 7
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              alu_rst,
  input  logic              issue,
  input  logic [REG_AW-1:0] issue_dst,
  input  logic [2:0]        issue_lat,
  input  logic              alu_valid,
  input  logic [31:0]       alu_r,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [31:0]       wb_dat,
  output logic [3:0]        pending,
  output logic              idle,
  output logic              err_collision,
  output logic              err_orphan
);

  // delay line: slot 0 is the head that lines up with alu_valid
  logic [LAT_MAX-1:0]             vld_pipe, vld_sh, vld_nxt;
  logic [LAT_MAX-1:0][REG_AW-1:0] dst_pipe, dst_sh, dst_nxt;
  logic                           lat_ok;
  logic                           retire;
  logic [3:0]                     cnt_nxt;

  assign lat_ok = (issue_lat != 3'd0) && (32'(issue_lat) <= LAT_MAX);
  assign retire = vld_pipe[0] & alu_valid;

  // shift every slot one step toward the head; the top slot fills empty
  always_comb begin
    vld_sh = '0;
    dst_sh = '0;
    for (int i = 0; i < LAT_MAX - 1; i++) begin
      vld_sh[i] = vld_pipe[i+1];
      dst_sh[i] = dst_pipe[i+1];
    end
  end

  // overlay a legal issue on slot lat-1; the new issue always wins
  always_comb begin
    vld_nxt = vld_sh;
    dst_nxt = dst_sh;
    if (issue && lat_ok) begin
      for (int i = 0; i < LAT_MAX; i++) begin
        if (32'(issue_lat) == 32'(i + 1)) begin
          vld_nxt[i] = 1'b1;
          dst_nxt[i] = issue_dst;
        end
      end
    end
  end

  // pending tracks the number of occupied slots after this edge, saturating
  always_comb begin
    cnt_nxt = 4'd0;
    for (int i = 0; i < LAT_MAX; i++) begin
      if (vld_nxt[i] && (cnt_nxt != 4'd15)) cnt_nxt = cnt_nxt + 4'd1;
    end
  end

  // delay line, occupancy count and write-back port state
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_pipe <= '0;
      dst_pipe <= '0;
      pending  <= 4'd0;
      wb_en    <= 1'b0;
      wb_addr  <= '0;
      wb_dat   <= 32'd0;
    end else if (alu_rst) begin
      vld_pipe <= '0;
      dst_pipe <= '0;
      pending  <= 4'd0;
      wb_en    <= 1'b0;
      wb_addr  <= '0;
      wb_dat   <= 32'd0;
    end else begin
      vld_pipe <= vld_nxt;
      dst_pipe <= dst_nxt;
      pending  <= cnt_nxt;
      wb_en    <= retire;
      if (retire) begin
        wb_addr <= dst_pipe[0];
        wb_dat  <= alu_r;
      end
    end
  end

  assign idle = (pending == 4'd0) && !wb_en;

`ifdef PFPU_WBCOLLECT_ERR_EN
  logic collide;

  // a legal issue collides when the entry shifting into its slot is live
  always_comb begin
    collide = 1'b0;
    if (issue && lat_ok) begin
      for (int i = 0; i < LAT_MAX; i++) begin
        if (32'(issue_lat) == 32'(i + 1)) collide = vld_sh[i];
      end
    end
  end

  // sticky error flags, cleared only by either reset
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_collision <= 1'b0;
      err_orphan    <= 1'b0;
    end else if (alu_rst) begin
      err_collision <= 1'b0;
      err_orphan    <= 1'b0;
    end else begin
      if (collide || (issue && !lat_ok)) err_collision <= 1'b1;
      if (alu_valid && !vld_pipe[0])     err_orphan    <= 1'b1;
    end
  end
`else
  assign err_collision = 1'b0;
  assign err_orphan    = 1'b0;
`endif

endmodule

// File: tb/tb_pfpu_wbcollect.sv
// Bench for pfpu_wbcollect: directed scenarios with constant expectations,
// then randomized traffic checked against a model that keys each in-flight
// result by the absolute cycle it is due at the ALU output.
module tb_pfpu_wbcollect;
  localparam int LAT_MAX = 7;
  localparam int REG_AW  = 7;
`ifdef PFPU_WBCOLLECT_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              alu_rst;
  logic              issue;
  logic [REG_AW-1:0] issue_dst;
  logic [2:0]        issue_lat;
  logic              alu_valid;
  logic [31:0]       alu_r;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [31:0]       wb_dat;
  logic [3:0]        pending;
  logic              idle;
  logic              err_collision;
  logic              err_orphan;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // reference model: destination keyed by the cycle the result is due
  logic [REG_AW-1:0] m_due [int];
  logic              m_wb_en;
  logic [REG_AW-1:0] m_wb_addr;
  logic [31:0]       m_wb_dat;
  logic              m_col;
  logic              m_orph;

  always #5 sys_clk = ~sys_clk;

  pfpu_wbcollect #(.LAT_MAX(LAT_MAX), .REG_AW(REG_AW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .alu_rst(alu_rst),
    .issue(issue), .issue_dst(issue_dst), .issue_lat(issue_lat),
    .alu_valid(alu_valid), .alu_r(alu_r),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_dat(wb_dat),
    .pending(pending), .idle(idle),
    .err_collision(err_collision), .err_orphan(err_orphan)
  );

  task automatic model_clear();
    m_due.delete();
    m_wb_en   = 1'b0;
    m_wb_addr = '0;
    m_wb_dat  = 32'd0;
    m_col     = 1'b0;
    m_orph    = 1'b0;
  endtask

  // drive one cycle of inputs, advance the model, then sample after the edge
  task automatic step(input logic i_iss, input logic [REG_AW-1:0] i_dst,
                      input logic [2:0] i_lat, input logic i_av,
                      input logic [31:0] i_r, input logic i_rst);
    int due;
    issue = i_iss; issue_dst = i_dst; issue_lat = i_lat;
    alu_valid = i_av; alu_r = i_r; alu_rst = i_rst;
    if (i_rst) model_clear();
    else begin
      if (i_av && m_due.exists(cyc)) begin
        m_wb_en = 1'b1; m_wb_addr = m_due[cyc]; m_wb_dat = i_r;
      end else begin
        m_wb_en = 1'b0;
        if (i_av && ERR) m_orph = 1'b1;
      end
      if (m_due.exists(cyc)) m_due.delete(cyc);
      if (i_iss) begin
        if (i_lat == 3'd0 || int'(i_lat) > LAT_MAX) begin
          if (ERR) m_col = 1'b1;
        end else begin
          due = cyc + int'(i_lat);
          if (m_due.exists(due) && ERR) m_col = 1'b1;
          m_due[due] = i_dst;
        end
      end
    end
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic nop();
    step(1'b0, '0, 3'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic flush();
    step(1'b0, '0, 3'd0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; alu_rst = 1'b0; issue = 1'b0; issue_dst = '0;
    issue_lat = 3'd0; alu_valid = 1'b0; alu_r = 32'd0;
    model_clear();
    repeat (3) @(posedge sys_clk);
    #1;
    n_chk++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en got %b exp 0", wb_en); end
    n_chk++; if (wb_addr !== 7'h00) begin n_fail++; $display("FAIL reset_wb_addr got %0h exp 0", wb_addr); end
    n_chk++; if (wb_dat !== 32'h0) begin n_fail++; $display("FAIL reset_wb_dat got %0h exp 0", wb_dat); end
    n_chk++; if (pending !== 4'd0) begin n_fail++; $display("FAIL reset_pending got %0d exp 0", pending); end
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b exp 1", idle); end
    n_chk++; if ({err_collision, err_orphan} !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b exp 00", {err_collision, err_orphan}); end
    sys_rst_n = 1'b1;
    nop();
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle_after got %b exp 1", idle); end
  endtask

  task automatic test_single();
    flush();
    step(1'b1, 7'h05, 3'd1, 1'b0, 32'd0, 1'b0);
    n_chk++; if (pending !== 4'd1) begin n_fail++; $display("FAIL single_pend got %0d exp 1", pending); end
    n_chk++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL single_early_wb got %b exp 0", wb_en); end
    step(1'b0, '0, 3'd0, 1'b1, 32'h3F80_0000, 1'b0);
    n_chk++; if (wb_en !== 1'b1) begin n_fail++; $display("FAIL single_wb_en got %b exp 1", wb_en); end
    n_chk++; if (wb_addr !== 7'h05) begin n_fail++; $display("FAIL single_wb_addr got %0h exp 05", wb_addr); end
    n_chk++; if (wb_dat !== 32'h3F80_0000) begin n_fail++; $display("FAIL single_wb_dat got %0h exp 3f800000", wb_dat); end
    n_chk++; if (pending !== 4'd0) begin n_fail++; $display("FAIL single_pend0 got %0d exp 0", pending); end
    n_chk++; if (idle !== 1'b0) begin n_fail++; $display("FAIL single_idle_wr got %b exp 0", idle); end
    nop();
    n_chk++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL single_wb_off got %b exp 0", wb_en); end
    n_chk++; if (wb_addr !== 7'h05 || wb_dat !== 32'h3F80_0000) begin n_fail++; $display("FAIL single_hold got %0h/%0h exp 05/3f800000", wb_addr, wb_dat); end
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle got %b exp 1", idle); end
  endtask

  task automatic test_reorder();
    flush();
    step(1'b1, 7'h10, 3'd3, 1'b0, 32'd0, 1'b0);
    n_chk++; if (pending !== 4'd1) begin n_fail++; $display("FAIL reorder_pend_c1 got %0d exp 1", pending); end
    step(1'b1, 7'h11, 3'd1, 1'b0, 32'd0, 1'b0);
    n_chk++; if (pending !== 4'd2) begin n_fail++; $display("FAIL reorder_pend_c2 got %0d exp 2", pending); end
    step(1'b0, '0, 3'd0, 1'b1, 32'hAAAA_0011, 1'b0);
    n_chk++; if (wb_en !== 1'b1 || wb_addr !== 7'h11 || wb_dat !== 32'hAAAA_0011) begin n_fail++; $display("FAIL reorder_wr1 got %b/%0h/%0h exp 1/11/aaaa0011", wb_en, wb_addr, wb_dat); end
    n_chk++; if (pending !== 4'd1) begin n_fail++; $display("FAIL reorder_pend_c3 got %0d exp 1", pending); end
    step(1'b0, '0, 3'd0, 1'b1, 32'hBBBB_0010, 1'b0);
    n_chk++; if (wb_en !== 1'b1 || wb_addr !== 7'h10 || wb_dat !== 32'hBBBB_0010) begin n_fail++; $display("FAIL reorder_wr2 got %b/%0h/%0h exp 1/10/bbbb0010", wb_en, wb_addr, wb_dat); end
    n_chk++; if (pending !== 4'd0 || idle !== 1'b0) begin n_fail++; $display("FAIL reorder_c4 got pend %0d idle %b exp 0/0", pending, idle); end
    nop();
    n_chk++; if (idle !== 1'b1 || wb_en !== 1'b0) begin n_fail++; $display("FAIL reorder_idle got idle %b wb %b exp 1/0", idle, wb_en); end
    n_chk++; if ({err_collision, err_orphan} !== 2'b00) begin n_fail++; $display("FAIL reorder_err got %b exp 00", {err_collision, err_orphan}); end
  endtask

  task automatic test_collision();
    flush();
    step(1'b1, 7'h20, 3'd2, 1'b0, 32'd0, 1'b0);
    step(1'b1, 7'h21, 3'd1, 1'b0, 32'd0, 1'b0);
    n_chk++; if (err_collision !== ERR) begin n_fail++; $display("FAIL coll_flag got %b exp %b", err_collision, ERR); end
    n_chk++; if (pending !== 4'd1) begin n_fail++; $display("FAIL coll_pend got %0d exp 1", pending); end
    step(1'b0, '0, 3'd0, 1'b1, 32'h1234_5678, 1'b0);
    n_chk++; if (wb_en !== 1'b1 || wb_addr !== 7'h21) begin n_fail++; $display("FAIL coll_wr got %b/%0h exp 1/21", wb_en, wb_addr); end
    step(1'b0, '0, 3'd0, 1'b1, 32'h0BAD_0020, 1'b0);
    n_chk++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL coll_no_20 got %b exp 0", wb_en); end
    n_chk++; if (err_collision !== ERR || err_orphan !== ERR) begin n_fail++; $display("FAIL coll_sticky got %b%b exp %b%b", err_collision, err_orphan, ERR, ERR); end
  endtask

  task automatic test_bad_lat();
    flush();
    step(1'b1, 7'h33, 3'd0, 1'b0, 32'd0, 1'b0);
    n_chk++; if (pending !== 4'd0) begin n_fail++; $display("FAIL badlat_pend got %0d exp 0", pending); end
    n_chk++; if (err_collision !== ERR) begin n_fail++; $display("FAIL badlat_flag got %b exp %b", err_collision, ERR); end
    step(1'b1, 7'h34, 3'd7, 1'b0, 32'd0, 1'b0);
    n_chk++; if (pending !== 4'd1) begin n_fail++; $display("FAIL maxlat_pend got %0d exp 1", pending); end
    repeat (6) nop();
    step(1'b0, '0, 3'd0, 1'b1, 32'h0000_0777, 1'b0);
    n_chk++; if (wb_en !== 1'b1 || wb_addr !== 7'h34) begin n_fail++; $display("FAIL maxlat_wr got %b/%0h exp 1/34", wb_en, wb_addr); end
  endtask

  task automatic test_orphan();
    flush();
    step(1'b0, '0, 3'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    n_chk++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL orph_wb got %b exp 0", wb_en); end
    n_chk++; if (err_orphan !== ERR) begin n_fail++; $display("FAIL orph_flag got %b exp %b", err_orphan, ERR); end
    repeat (3) nop();
    n_chk++; if (err_orphan !== ERR || wb_en !== 1'b0) begin n_fail++; $display("FAIL orph_sticky got %b/%b exp %b/0", err_orphan, wb_en, ERR); end
    flush();
    n_chk++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL orph_clear got %b exp 0", err_orphan); end
  endtask

  task automatic test_flush_mid();
    flush();
    step(1'b1, 7'h40, 3'd4, 1'b0, 32'd0, 1'b0);
    nop();
    n_chk++; if (pending !== 4'd1) begin n_fail++; $display("FAIL flush_pre got %0d exp 1", pending); end
    step(1'b1, 7'h41, 3'd1, 1'b1, 32'd0, 1'b1);
    n_chk++; if (pending !== 4'd0) begin n_fail++; $display("FAIL flush_pend got %0d exp 0", pending); end
    nop();
    step(1'b0, '0, 3'd0, 1'b1, 32'h4040_4040, 1'b0);
    n_chk++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL flush_nowr got %b exp 0", wb_en); end
    n_chk++; if (err_orphan !== ERR) begin n_fail++; $display("FAIL flush_orph got %b exp %b", err_orphan, ERR); end
  endtask

  task automatic test_async_reset();
    flush();
    step(1'b1, 7'h50, 3'd3, 1'b0, 32'd0, 1'b0);
    step(1'b1, 7'h51, 3'd1, 1'b0, 32'd0, 1'b0);
    step(1'b0, '0, 3'd0, 1'b1, 32'h5151_5151, 1'b0);
    nop();
    #2 sys_rst_n = 1'b0;
    #1;
    n_chk++; if (wb_en !== 1'b0 || wb_addr !== 7'h00 || wb_dat !== 32'h0) begin n_fail++; $display("FAIL arst_wb got %b/%0h/%0h exp 0/0/0", wb_en, wb_addr, wb_dat); end
    n_chk++; if (pending !== 4'd0 || idle !== 1'b1) begin n_fail++; $display("FAIL arst_pend got %0d idle %b exp 0/1", pending, idle); end
    n_chk++; if ({err_collision, err_orphan} !== 2'b00) begin n_fail++; $display("FAIL arst_err got %b exp 00", {err_collision, err_orphan}); end
    #1 sys_rst_n = 1'b1;
    model_clear();
    step(1'b0, '0, 3'd0, 1'b1, 32'h5050_5050, 1'b0);
    n_chk++; if (wb_en !== 1'b0 || pending !== 4'd0) begin n_fail++; $display("FAIL arst_gone got %b/%0d exp 0/0", wb_en, pending); end
    flush();
  endtask

  task automatic test_random();
    logic              r_iss, r_av, r_rst;
    logic [REG_AW-1:0] r_dst;
    logic [2:0]        r_lat;
    logic [31:0]       r_dat;
    logic [3:0]        e_pend;
    flush();
    for (int k = 0; k < 400; k++) begin
      r_iss = ($urandom_range(0, 99) < 55);
      r_dst = REG_AW'($urandom_range(0, (1 << REG_AW) - 1));
      r_lat = ($urandom_range(0, 19) == 0) ? 3'd0 : 3'($urandom_range(1, LAT_MAX));
      r_av  = m_due.exists(cyc) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 19) == 0);
      r_dat = $urandom;
      r_rst = ($urandom_range(0, 49) == 0);
      step(r_iss, r_dst, r_lat, r_av, r_dat, r_rst);
      e_pend = (m_due.num() > 15) ? 4'd15 : 4'(m_due.num());
      n_chk++; if (wb_en !== m_wb_en) begin n_fail++; $display("FAIL rnd_wb_en cyc %0d got %b exp %b", cyc, wb_en, m_wb_en); end
      n_chk++; if (wb_addr !== m_wb_addr || wb_dat !== m_wb_dat) begin n_fail++; $display("FAIL rnd_wb_data cyc %0d got %0h/%0h exp %0h/%0h", cyc, wb_addr, wb_dat, m_wb_addr, m_wb_dat); end
      n_chk++; if (pending !== e_pend) begin n_fail++; $display("FAIL rnd_pending cyc %0d got %0d exp %0d", cyc, pending, e_pend); end
      n_chk++; if (idle !== (e_pend == 4'd0 && !m_wb_en)) begin n_fail++; $display("FAIL rnd_idle cyc %0d got %b", cyc, idle); end
      n_chk++; if (err_collision !== m_col || err_orphan !== m_orph) begin n_fail++; $display("FAIL rnd_err cyc %0d got %b%b exp %b%b", cyc, err_collision, err_orphan, m_col, m_orph); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reorder();
    test_collision();
    test_bad_lat();
    test_orphan();
    test_flush_mid();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
